// File: rtl/ucsbece154_icache_refill.sv
// Instruction-cache refill initiator: issues one burst read per miss, returns the demand
// line critical-word-first with early restart, and keeps the sequentially next line in a
// one-entry prefetch buffer that can satisfy a later miss without touching memory.
module ucsbece154_icache_refill #(
  parameter int unsigned BLOCK_WORDS     = 4,
  parameter int unsigned LOG_BLOCK_WORDS = $clog2(BLOCK_WORDS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MissValid,
  input  logic [31:0]                MissAddress,
  output logic                       MissReady,
  input  logic                       PfInvalidate,
  output logic                       CritValid,
  output logic [31:0]                CritWord,
  output logic                       LineValid,
  output logic [31:0]                LineAddress,
  output logic [32*BLOCK_WORDS-1:0]  LineData,
  output logic                       ProtoErr,
  output logic                       ReadRequest,
  output logic [31:0]                ReadAddress,
  input  logic [31:0]                DataIn,
  input  logic                       DataReady,
  input  logic [LOG_BLOCK_WORDS-1:0] block_index
);

  // Byte-offset bits within a line, and a counter wide enough for 2*BLOCK_WORDS beats.
  localparam int unsigned OffW = LOG_BLOCK_WORDS + 2;
  localparam int unsigned CntW = LOG_BLOCK_WORDS + 1;
  localparam logic [CntW-1:0] LastDemand = CntW'(BLOCK_WORDS - 1);
  localparam logic [CntW-1:0] LastBeat   = CntW'(2 * BLOCK_WORDS - 1);
  localparam logic [31:0]     LineBytes  = 32'(4 * BLOCK_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StPfHit,
    StReq,
    StWait,
    StDemand,
    StPrefetch
  } state_e;

  state_e                    state;
  logic [CntW-1:0]           beat_cnt;
  logic                      pf_valid;
  logic                      discard;
  logic [31:0]               pf_tag;
  logic [32*BLOCK_WORDS-1:0] pf_buf;
  logic [32*BLOCK_WORDS-1:0] line_buf;
  logic [32*BLOCK_WORDS-1:0] line_merged;
  logic [31:0]               miss_line;
  logic [31:0]               req_line;
  logic                      pf_hit;

  assign miss_line   = {MissAddress[31:OffW], {OffW{1'b0}}};
  assign req_line    = {ReadAddress[31:OffW], {OffW{1'b0}}};
  assign pf_hit      = pf_valid && (miss_line == pf_tag) && !PfInvalidate;
  assign MissReady   = (state == StIdle);
  assign ReadRequest = (state == StReq);

  // Demand line including the beat arriving this cycle, so the last beat can publish at once.
  always_comb begin
    line_merged = line_buf;
    line_merged[{block_index, 5'b00000} +: 32] = DataIn;
  end

  // Refill FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= StIdle;
      beat_cnt    <= '0;
      pf_valid    <= 1'b0;
      discard     <= 1'b0;
      pf_tag      <= '0;
      pf_buf      <= '0;
      line_buf    <= '0;
      CritValid   <= 1'b0;
      CritWord    <= '0;
      LineValid   <= 1'b0;
      LineAddress <= '0;
      LineData    <= '0;
      ProtoErr    <= 1'b0;
      ReadAddress <= '0;
    end else begin
      CritValid <= 1'b0;
      LineValid <= 1'b0;
      ProtoErr  <= 1'b0;
      if (PfInvalidate) pf_valid <= 1'b0;

      unique case (state)
        StIdle: begin
          if (MissValid) begin
            if (pf_hit) begin
              // Served from the buffer; results are loaded now so they appear next cycle.
              LineData    <= pf_buf;
              LineAddress <= pf_tag;
              CritWord    <= pf_buf[{MissAddress[OffW-1:2], 5'b00000} +: 32];
              CritValid   <= 1'b1;
              LineValid   <= 1'b1;
              pf_valid    <= 1'b0;
              state       <= StPfHit;
            end else begin
              ReadAddress <= MissAddress;
              state       <= StReq;
            end
          end
        end

        StPfHit: state <= StIdle;

        StReq: begin
          pf_valid <= 1'b0;
          beat_cnt <= '0;
          state    <= StWait;
        end

        StWait, StDemand: begin
          if (PfInvalidate) discard <= 1'b1;
          if (DataReady) begin
            line_buf <= line_merged;
            beat_cnt <= beat_cnt + CntW'(1);
            if (state == StWait) begin
              // Early restart: the first beat is the requested instruction.
              CritWord  <= DataIn;
              CritValid <= 1'b1;
              if (block_index != ReadAddress[OffW-1:2]) ProtoErr <= 1'b1;
            end
            if (beat_cnt == LastDemand) begin
              LineData    <= line_merged;
              LineAddress <= req_line;
              LineValid   <= 1'b1;
              state       <= StPrefetch;
            end else begin
              state <= StDemand;
            end
          end
        end

        StPrefetch: begin
          if (PfInvalidate) discard <= 1'b1;
          if (DataReady) begin
            pf_buf[{block_index, 5'b00000} +: 32] <= DataIn;
            // Prefetch beats arrive in order, so the low counter bits are the expected index.
            if (block_index != beat_cnt[LOG_BLOCK_WORDS-1:0]) ProtoErr <= 1'b1;
            beat_cnt <= beat_cnt + CntW'(1);
            if (beat_cnt == LastBeat) begin
              pf_tag   <= req_line + LineBytes;
              pf_valid <= !discard && !PfInvalidate;
              discard  <= 1'b0;
              state    <= StIdle;
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154_icache_refill.sv
// Directed bench for the I-cache refill initiator with an inline burst memory model.
module tb_ucsbece154_icache_refill;

  localparam int T0 = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic         MissValid;
  logic [31:0]  MissAddress;
  logic         MissReady;
  logic         PfInvalidate;
  logic         CritValid;
  logic [31:0]  CritWord;
  logic         LineValid;
  logic [31:0]  LineAddress;
  logic [127:0] LineData;
  logic         ProtoErr;
  logic         ReadRequest;
  logic [31:0]  ReadAddress;
  logic [31:0]  DataIn;
  logic         DataReady;
  logic [1:0]   block_index;

  int n_cmp = 0;
  int n_err = 0;

  ucsbece154_icache_refill #(.BLOCK_WORDS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .MissValid    (MissValid),
    .MissAddress  (MissAddress),
    .MissReady    (MissReady),
    .PfInvalidate (PfInvalidate),
    .CritValid    (CritValid),
    .CritWord     (CritWord),
    .LineValid    (LineValid),
    .LineAddress  (LineAddress),
    .LineData     (LineData),
    .ProtoErr     (ProtoErr),
    .ReadRequest  (ReadRequest),
    .ReadAddress  (ReadAddress),
    .DataIn       (DataIn),
    .DataReady    (DataReady),
    .block_index  (block_index)
  );

  always #5 clk = ~clk;

  // TEXT[i] lives at 0x00010000 + 4*i.
  function automatic logic [31:0] text(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete memory fill; stall adds 3 idle cycles after beat 1, inval pulses
  // PfInvalidate on prefetch beat 1, bad starts the demand burst one word early.
  task automatic fill(input logic [31:0] addr, input bit stall, input bit inval, input bit bad);
    int base;
    int c;
    int s;
    int idx;
    int perr;
    logic [127:0] exp_line;
    base = int'((addr - 32'h0001_0000) >> 2) & ~3;
    c    = int'(addr[3:2]);
    s    = bad ? (c + 3) % 4 : c;
    perr = 0;
    for (int i = 0; i < 4; i++) exp_line[32*i +: 32] = text(base + i);

    MissValid   = 1'b1;
    MissAddress = addr;
    tick();
    MissValid = 1'b0;
    chk("read_request", ReadRequest, 1'b1);
    chk("read_address", ReadAddress, addr);
    chk("miss_ready_busy", MissReady, 1'b0);
    tick();
    chk("read_request_pulse", ReadRequest, 1'b0);
    repeat (T0) tick();

    for (int k = 0; k < 4; k++) begin
      idx         = (s + k) % 4;
      DataReady   = 1'b1;
      DataIn      = text(base + idx);
      block_index = 2'(idx);
      tick();
      DataReady = 1'b0;
      perr += int'(ProtoErr);
      if (k == 0) begin
        chk("crit_valid", CritValid, 1'b1);
        chk("crit_word", CritWord, text(base + s));
      end
      if (stall && k == 1) begin
        repeat (3) begin
          tick();
          chk("line_valid_stall", LineValid, 1'b0);
        end
      end
    end
    chk("line_valid", LineValid, 1'b1);
    chk("line_address", LineAddress, addr & 32'hFFFF_FFF0);
    chk("line_data", LineData, exp_line);
    chk("miss_ready_after_line", MissReady, 1'b0);

    for (int k = 0; k < 4; k++) begin
      PfInvalidate = inval && (k == 1);
      DataReady    = 1'b1;
      DataIn       = text(base + 4 + k);
      block_index  = 2'(k);
      tick();
      DataReady    = 1'b0;
      PfInvalidate = 1'b0;
      perr += int'(ProtoErr);
      if (k == 0) chk("line_valid_pulse", LineValid, 1'b0);
      if (k == 3) chk("miss_ready_done", MissReady, 1'b1);
    end
    chk("proto_err_count", perr, bad ? 1 : 0);
  endtask

  initial begin
    reset        = 1'b0;
    MissValid    = 1'b0;
    MissAddress  = '0;
    PfInvalidate = 1'b0;
    DataIn       = '0;
    DataReady    = 1'b0;
    block_index  = '0;
    tick();
    tick();

    // Reset state.
    chk("rst_miss_ready", MissReady, 1'b1);
    chk("rst_read_request", ReadRequest, 1'b0);
    chk("rst_crit_valid", CritValid, 1'b0);
    chk("rst_crit_word", CritWord, 32'h0);
    chk("rst_line_valid", LineValid, 1'b0);
    chk("rst_line_address", LineAddress, 32'h0);
    chk("rst_line_data", LineData, 128'h0);
    chk("rst_proto_err", ProtoErr, 1'b0);
    chk("rst_read_address", ReadAddress, 32'h0);
    chk("rst_pf_valid", dut.pf_valid, 1'b0);
    reset = 1'b1;
    tick();

    // Demand fill of 0x00010008 followed by the next line into the buffer.
    fill(32'h0001_0008, 1'b0, 1'b0, 1'b0);
    chk("s1_pf_valid", dut.pf_valid, 1'b1);
    chk("s1_pf_tag", dut.pf_tag, 32'h0001_0010);

    // Prefetch hit on 0x00010014.
    MissValid   = 1'b1;
    MissAddress = 32'h0001_0014;
    tick();
    MissValid = 1'b0;
    chk("s2_read_request", ReadRequest, 1'b0);
    chk("s2_line_valid", LineValid, 1'b1);
    chk("s2_crit_valid", CritValid, 1'b1);
    chk("s2_crit_word", CritWord, text(5));
    chk("s2_line_address", LineAddress, 32'h0001_0010);
    chk("s2_line_data", LineData, {text(7), text(6), text(5), text(4)});
    chk("s2_miss_ready_busy", MissReady, 1'b0);
    tick();
    chk("s2_miss_ready", MissReady, 1'b1);
    chk("s2_line_valid_pulse", LineValid, 1'b0);
    chk("s2_read_request_idle", ReadRequest, 1'b0);
    chk("s2_pf_consumed", dut.pf_valid, 1'b0);

    // Same miss again: the buffer is spent, so memory is asked.
    fill(32'h0001_0014, 1'b0, 1'b0, 1'b0);
    chk("s3_pf_valid", dut.pf_valid, 1'b1);
    chk("s3_pf_tag", dut.pf_tag, 32'h0001_0020);

    // Invalidate during a prefetch beat discards the buffered line.
    fill(32'h0001_0008, 1'b0, 1'b1, 1'b0);
    chk("s4_pf_discarded", dut.pf_valid, 1'b0);
    MissValid   = 1'b1;
    MissAddress = 32'h0001_0014;
    tick();
    MissValid = 1'b0;
    chk("s4_read_request", ReadRequest, 1'b1);
    chk("s4_pf_valid", dut.pf_valid, 1'b0);
    tick();

    // Reset while waiting (with a discard pending) returns everything to idle.
    PfInvalidate = 1'b1;
    tick();
    PfInvalidate = 1'b0;
    reset        = 1'b0;
    tick();
    chk("s5_miss_ready", MissReady, 1'b1);
    chk("s5_read_request", ReadRequest, 1'b0);
    chk("s5_line_data", LineData, 128'h0);
    chk("s5_line_address", LineAddress, 32'h0);
    chk("s5_crit_word", CritWord, 32'h0);
    chk("s5_read_address", ReadAddress, 32'h0);
    chk("s5_pf_valid", dut.pf_valid, 1'b0);
    reset = 1'b1;
    tick();
    fill(32'h0001_0008, 1'b0, 1'b0, 1'b0);
    chk("s5_discard_cleared", dut.pf_valid, 1'b1);

    // Mid-burst stall, then a misordered first beat.
    fill(32'h0001_0008, 1'b1, 1'b0, 1'b0);
    fill(32'h0001_0008, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ucsbece154_icache_refill.md
# ucsbece154_icache_refill

Instruction-cache refill initiator that sits between the I-cache miss logic and the instruction memory burst interface. It accepts one miss at a time and issues a single-cycle `ReadRequest`. It then collects a 2×BLOCK_WORDS burst: the first BLOCK_WORDS beats are the demand line, delivered critical-word-first and wrapping; the next BLOCK_WORDS beats are the sequentially next line, delivered in order. The demand line goes to the cache, with early restart of the critical word. The next line is held in a one-entry prefetch buffer that can satisfy a later miss without a memory access.

## Interface
Parameters:
- `BLOCK_WORDS`, 4 — words per line; power of two; must match the memory burst length.
- `LOG_BLOCK_WORDS`, `$clog2(BLOCK_WORDS)` — derived; do not override.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-low (0 = reset).
- `MissValid`  in  1  — miss request from the cache.
- `MissAddress`  in  32  — byte address of the missing instruction, word aligned.
- `MissReady`  out  1  — high only in IDLE; a miss is accepted when `MissValid & MissReady`.
- `PfInvalidate`  in  1  — invalidates the prefetch buffer (fence.i / flush).
- `CritValid`  out  1  — one-cycle pulse: `CritWord` is the requested instruction.
- `CritWord`  out  32  — registered critical word.
- `LineValid`  out  1  — one-cycle pulse: `LineAddress`/`LineData` hold a complete line.
- `LineAddress`  out  32  — line-aligned address: `MissAddress` with bits [LOG_BLOCK_WORDS+1:0] cleared.
- `LineData`  out  32×BLOCK_WORDS  — word i occupies bits [32i+31:32i].
- `ProtoErr`  out  1  — one-cycle pulse on a burst ordering violation.
- `ReadRequest`  out  1  — to memory; high for exactly one cycle per fill.
- `ReadAddress`  out  32  — to memory; registered `MissAddress`, stable from the REQ cycle until the fill returns to IDLE.
- `DataIn`  in  32  — burst data from memory.
- `DataReady`  in  1  — `DataIn` is valid this cycle (one beat).
- `block_index`  in  LOG_BLOCK_WORDS  — word offset of the current beat within its line.

## Operation
States:
- **IDLE**
  - Accepted miss with a prefetch hit → PF_HIT.
  - Accepted miss without a prefetch hit → REQ.
  - A prefetch hit is `pf_valid & (line(MissAddress) == pf_tag) & !PfInvalidate`.
- **PF_HIT** — one cycle.
  - Loads `LineData` from the buffer; `LineAddress` = `pf_tag`.
  - Loads `CritWord` = buffer[MissAddress[LOG_BLOCK_WORDS+1:2]].
  - Clears `pf_valid`.
  - Next state: IDLE. No memory request is issued.
- **REQ** — one cycle. `ReadRequest`=1; clears `pf_valid` and the beat counter. Next state: WAIT.
- **WAIT** — stays until the first `DataReady`; that beat is beat 0 → DEMAND.
- **DEMAND** — beats 0..BLOCK_WORDS-1.
  - Each beat writes `DataIn` into line word `block_index`.
  - Beat 0 loads `CritWord`.
  - After beat BLOCK_WORDS-1 → PREFETCH.
- **PREFETCH** — beats BLOCK_WORDS..2·BLOCK_WORDS-1.
  - Each beat writes `DataIn` into buffer word `block_index`.
  - After the last beat: `pf_tag` = line base + 4·BLOCK_WORDS (mod 2³²); `pf_valid` is set unless a discard is pending; next state IDLE.

Rules:
- The beat counter advances only on cycles with `DataReady`=1; a low `DataReady` mid-burst stalls the FSM with no timeout. `DataReady` is ignored in IDLE, PF_HIT and REQ.
- Burst ordering checks: beat 0 `block_index` must equal `MissAddress[LOG_BLOCK_WORDS+1:2]`, and prefetch beat k must carry index k. A mismatch pulses `ProtoErr` the next cycle. The data is still stored at `block_index`.
- `PfInvalidate`:
  - Clears `pf_valid` the next cycle.
  - If asserted during WAIT, DEMAND or PREFETCH, sets a sticky discard flag; the flag suppresses `pf_valid` at the end of the burst and is cleared on return to IDLE.
  - In IDLE, `PfInvalidate` together with a matching `MissValid` forces the REQ path.
- `MissReady` stays 0 until PREFETCH completes, even after `LineValid`.
- Reset mid-fill: the next cycle is IDLE with `pf_valid`=0 and the discard flag cleared. The memory model shares this reset.

## Timing
- Reset values: `MissReady`=1; `pf_valid`=0; every other output 0 (`ReadRequest`, `CritValid`, `CritWord`, `LineValid`, `LineAddress`, `LineData`, `ProtoErr`, `ReadAddress`).
- Memory miss accepted at cycle t:
  - `ReadRequest` high at t+1.
  - With the memory's first-word delay T0, beat 0 arrives at t+2+T0.
  - `CritValid` pulses one cycle after beat 0.
  - `LineValid` pulses one cycle after beat BLOCK_WORDS-1.
  - `MissReady` returns to 1 one cycle after the last prefetch beat.
- Prefetch hit accepted at cycle t: `LineValid`=`CritValid`=1 at t+1; `MissReady`=1 at t+2.
- `LineData`, `LineAddress` and `CritWord` hold their values until the next load.

## Test plan
Common setup: BLOCK_WORDS=4, T0=40, TEXT[i] at 0x00010000+4i.
1. Miss 0x00010008 → `ReadRequest` for one cycle with address 0x00010008. Beats carry indices 2,3,0,1 then 0,1,2,3. `CritValid` with `CritWord`=TEXT[2]. `LineValid` with `LineAddress`=0x00010000 and `LineData`=TEXT[0..3]. Afterwards `pf_valid`=1, `pf_tag`=0x00010010.
2. Following scenario 1, miss 0x00010014 → no `ReadRequest`. `LineValid`=`CritValid`=1 one cycle after accept; `CritWord`=TEXT[5]; `LineData`=TEXT[4..7].
3. Repeat the miss 0x00010014 → buffer already consumed, so `ReadRequest` is issued.
4. `PfInvalidate` pulsed during a prefetch beat, then miss 0x00010014 → `ReadRequest` issued and `pf_valid` remains 0.
5. `reset`=0 during WAIT → next cycle all outputs are 0, `MissReady`=1. A new miss then issues a fresh `ReadRequest`.
6. Hold `DataReady` low for 3 cycles between beats 1 and 2 → the line is still correct and `LineValid` is delayed by 3 cycles. Beat 0 with `block_index`=1 for miss 0x00010008 → `ProtoErr` pulses once.
